// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encodings, byte width, default watchdog length.
package uart_pkg;

    localparam int unsigned UART_DATA_W        = 8;
    localparam int unsigned ARB_TIMEOUT_CYCLES = 200000;

    // One-hot arbiter states
    typedef enum logic [3:0] {
        ARB_IDLE         = 4'b0001,
        ARB_START        = 4'b0010,
        ARB_WAIT_DONE    = 4'b0100,
        ARB_WAIT_RELEASE = 4'b1000
    } arb_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational round-robin picker: first set request after last_grant_i (wrapping).
//   req_i        : request vector
//   last_grant_i : index served most recently
//   grant_o      : one-hot winner (zero if no request)
//   idx_o        : index of winner
//   any_o        : at least one request present
module rr_priority_select #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int unsigned cand;
    logic        found;

    // Walk last_grant+1 .. last_grant+N_REQ (mod N_REQ); the first hit wins
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = (32'(last_grant_i) + i) % N_REQ;
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = IDX_W'(cand);
            end
        end
        any_o = found;
    end

endmodule : rr_priority_select

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte producers.
//   i_clock, i_reset     : clock, synchronous active-high reset
//   i_req_valid/_data    : per-requester byte offers (requester k at [k*DATA_W +: DATA_W])
//   o_req_ready          : combinational one-hot accept, only in IDLE
//   o_tx_start/_data     : one-cycle start pulse and held byte to the transmitter
//   i_tx_done            : transmitter done level (high during stop bit)
//   o_busy, o_grant_id   : frame in progress, owner of the current frame
//   o_timeout            : one-cycle pulse when the watchdog aborts a frame
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned DATA_W         = UART_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [N_REQ-1:0]           i_req_valid,
    input  logic [N_REQ*DATA_W-1:0]    i_req_data,
    output logic [N_REQ-1:0]           o_req_ready,
    output logic                       o_tx_start,
    output logic [DATA_W-1:0]          o_tx_data,
    input  logic                       i_tx_done,
    output logic                       o_busy,
    output logic [$clog2(N_REQ)-1:0]   o_grant_id,
    output logic                       o_timeout
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]  WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);
    // Counter value in the cycle before it reaches TIMEOUT_CYCLES-1
    localparam logic [WD_W-1:0]  WD_HIT = WD_W'(TIMEOUT_CYCLES - 2);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  last_grant_q, last_grant_d;
    logic [IDX_W-1:0]  grant_id_q, grant_id_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;

    logic [N_REQ-1:0]  sel_grant;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_any;
    logic [DATA_W-1:0] sel_data;
    logic              accept;
    logic [WD_W-1:0]   wd_inc;
    logic              wd_hit;

    rr_priority_select #(
        .N_REQ (N_REQ)
    ) u_rr_select (
        .req_i        (i_req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (sel_grant),
        .idx_o        (sel_idx),
        .any_o        (sel_any)
    );

    assign sel_data    = i_req_data[32'(sel_idx)*DATA_W +: DATA_W];
    assign o_req_ready = (state_q == ARB_IDLE) ? sel_grant : '0;
    assign accept      = (state_q == ARB_IDLE) && sel_any;
    assign wd_inc      = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + 1'b1;
    assign wd_hit      = (wd_cnt_q == WD_HIT);

    // State and output registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= LAST_RST;
            grant_id_q   <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            wd_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
            wd_cnt_q     <= wd_cnt_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        timeout_d    = 1'b0;
        wd_cnt_d     = wd_cnt_q;

        case (state_q)
            ARB_IDLE: begin
                if (accept) begin
                    state_d      = ARB_START;
                    tx_data_d    = sel_data;
                    grant_id_d   = sel_idx;
                    last_grant_d = sel_idx;
                    tx_start_d   = 1'b1;
                end
            end
            ARB_START: begin
                wd_cnt_d = '0;
                state_d  = ARB_WAIT_DONE;
            end
            ARB_WAIT_DONE: begin
                wd_cnt_d = wd_inc;
                // A done arriving on the timeout cycle wins: the transmitter is in
                // its stop bit, so releasing to IDLE now could start a frame early.
                if (i_tx_done) begin
                    state_d = ARB_WAIT_RELEASE;
                end else if (wd_hit) begin
                    state_d   = ARB_IDLE;
                    timeout_d = 1'b1;
                end
            end
            ARB_WAIT_RELEASE: begin
                wd_cnt_d = wd_inc;
                // Release coinciding with the timeout is a normal completion
                if (!i_tx_done) begin
                    state_d = ARB_IDLE;
                end else if (wd_hit) begin
                    state_d   = ARB_IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        busy_d = (state_d != ARB_IDLE);
    end

    assign o_tx_start = tx_start_q;
    assign o_tx_data  = tx_data_q;
    assign o_busy     = busy_q;
    assign o_grant_id = grant_id_q;
    assign o_timeout  = timeout_q;

endmodule : uart_tx_arbiter

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the single UART transmitter among `N_REQ` byte producers, such as the ALU result path, status reporter and echo path. It sits between the requesters' valid/ready byte interfaces and the transmitter's start/data/done interface. It accepts one byte at a time, launches exactly one frame per accepted byte, and holds off further grants until the transmitter has returned to idle. A watchdog recovers the arbiter if the transmitter never completes a frame.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2–8.
- `DATA_W`, default 8: byte width; must match the transmitter.
- `TIMEOUT_CYCLES`, default 200000: clock cycles allowed from `o_tx_start` to frame completion before abort; must be ≥ 2.
- `i_clock`, in, 1: system clock.
- `i_reset`, in, 1: reset, synchronous, active-high; clock is `i_clock`.
- `i_req_valid`, in, `N_REQ`: per-requester byte available.
- `i_req_data`, in, `N_REQ*DATA_W`: packed bytes; requester k occupies bits `[k*DATA_W +: DATA_W]`.
- `o_req_ready`, out, `N_REQ`: one-hot or zero; byte k is accepted in any cycle where `i_req_valid[k] && o_req_ready[k]`.
- `o_tx_start`, out, 1: one-cycle pulse to the transmitter.
- `o_tx_data`, out, `DATA_W`: byte to transmit; stable from the start pulse until the arbiter returns to IDLE.
- `i_tx_done`, in, 1: transmitter done level; high during the stop bit.
- `o_busy`, out, 1: high in every state except IDLE.
- `o_grant_id`, out, `$clog2(N_REQ)`: index of the requester that owns the current frame.
- `o_timeout`, out, 1: one-cycle pulse when a frame is aborted by the watchdog.

## Operation
- The FSM uses one-hot encoding with 4 states: IDLE, START, WAIT_DONE, WAIT_RELEASE.
- **IDLE**
  - Round-robin select starts at `last_grant+1` mod `N_REQ` and picks the first set `i_req_valid` bit.
  - `o_req_ready` is driven combinationally to the one-hot of the winner. It is all-zero if no request is valid, and all-zero in every other state.
  - On acceptance: latch the selected byte into `o_tx_data`, latch its index into `o_grant_id` and `last_grant`, then go to START.
- **START**: `o_tx_start`=1 for this cycle only. Clear the watchdog counter, then go to WAIT_DONE.
- **WAIT_DONE**: stay until `i_tx_done`=1 is sampled, then go to WAIT_RELEASE.
- **WAIT_RELEASE**: stay until `i_tx_done`=0 is sampled, then go to IDLE. The frame is complete here.
- **Watchdog**
  - The counter increments every cycle in WAIT_DONE and WAIT_RELEASE.
  - When it reaches `TIMEOUT_CYCLES-1`, go to IDLE and pulse `o_timeout` for 1 cycle.
  - `last_grant` is kept, so fairness still advances past the stalled requester.
  - The counter is `$clog2(TIMEOUT_CYCLES)` bits wide, saturates, and never wraps.
- **Pointer wrap**: after requester `N_REQ-1` is served, requester 0 has the highest priority.
- **Simultaneous requests**: exactly one is granted per frame. A requester that holds valid continuously is served at most once per `N_REQ` frames while others are waiting.
- **Valid dropped before acceptance**: allowed. The byte is not sent, and no state changes.
- **Watchdog vs. release in the same cycle**: a timeout coinciding with `i_tx_done` falling in WAIT_RELEASE counts as normal completion, so `o_timeout` stays 0.

## Timing
- **Reset values**: state IDLE; `o_req_ready`=0, `o_tx_start`=0, `o_tx_data`=0, `o_busy`=0, `o_grant_id`=0, `o_timeout`=0, watchdog=0, `last_grant`=`N_REQ-1` (requester 0 has first priority).
- **Reset mid-frame**: the frame is abandoned and no `o_timeout` is issued. The transmitter shares `i_reset`.
- **Accept-to-start latency**: acceptance in cycle t gives `o_tx_start`=1 in cycle t+1 and `o_busy`=1 from t+1.
- **Back-to-back**: `i_tx_done`=0 sampled in WAIT_RELEASE at cycle k gives IDLE at k+1; acceptance is possible at k+1 and the next start at k+2.
- **Transmitter-side handshake**: `o_tx_start` is never asserted while the transmitter is outside idle.
- **Requester-side handshake**: `o_req_ready` never depends on `i_req_data`; it does depend combinationally on `i_req_valid`.

## Structure
- **Shared package `uart_pkg`**
  - State encodings: `ARB_IDLE`=4'b0001, `ARB_START`=4'b0010, `ARB_WAIT_DONE`=4'b0100, `ARB_WAIT_RELEASE`=4'b1000.
  - `UART_DATA_W`=8.
  - The default `TIMEOUT_CYCLES`.
- **Sub-module `rr_priority_select`**: purely combinational.
  - Inputs: `N_REQ` request vector and `last_grant`.
  - Outputs: one-hot grant and index.
  - The arbiter FSM, pointer, data latch and watchdog stay in `uart_tx_arbiter`.

## Test plan
- **Single request**: `N_REQ`=4, `i_req_valid`=4'b0100 with data `8'hA5`, and a transmitter model that raises done 160 cycles after start for 16 cycles. Required: `o_req_ready`=4'b0100 in the same cycle, `o_tx_start` one cycle later with `o_tx_data`=`8'hA5`, `o_grant_id`=2, and `o_busy` low 1 cycle after done falls.
- **Round-robin fairness**: all 4 valid continuously with bytes `8'h10`–`8'h13`. Required: grants in order 0,1,2,3,0 and `o_tx_data` sequence `10,11,12,13,10`, with exactly one start per frame.
- **Back-to-back gap**: two queued requesters. Required: the second `o_tx_start` occurs exactly 2 cycles after the cycle in which `i_tx_done` is sampled low.
- **Watchdog**: `TIMEOUT_CYCLES`=50 and a transmitter model that never raises done. Required: `o_timeout` pulses exactly once, 50 cycles after start; the arbiter returns to IDLE, and the next grant goes to the following requester.
- **Reset mid-frame**: assert `i_reset` for 1 cycle during WAIT_DONE. Required: next cycle all outputs are at their reset values and `o_timeout`=0; requester 0 wins when requesters 0 and 3 are both valid.
